timer_ctrl: RTL

- Memory-mapped controller that configures, sequences and monitors a prescaled up-counter timer for the RISC-V core.
- Provides software control over:
  - enable
  - prescale
  - compare value
  - one-shot or auto-reload mode
  - a sticky match flag and a level interrupt to the core's interrupt logic.
- Sits on the core's peripheral bus next to other utility blocks.

---
 rtl/timer_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/timer_ctrl.sv
// timer_ctrl: memory-mapped controller for a prescaled up-counter timer.
//
// Registers (word index = byte addr[4:2]):
//   0 CTRL     [0] EN, [1] AUTO (auto-reload), [2] IE (irq enable)
//   1 PRESCALE tick period = PRESCALE+1 clocks
//   2 COMPARE  match period = COMPARE+1 ticks
//   3 COUNT
//   4 STATUS   [0] MATCH (sticky, W1C), [1] CAP (capture build only, W1C)
//   5 CAPTURE  (capture build only, otherwise reads 0)
//
// Ports:
//   clk    system clock
//   rst    asynchronous reset, active-low
//   sel    bus access strobe, one cycle per access
//   we     1 = write, 0 = read (valid with sel)
//   addr   word index
//   wdata  write data
//   rdata  registered read data, held between reads
//   ready  one-cycle pulse in the cycle after each sampled sel
//   irq    level interrupt, registered
//   cap_in capture strobe, used only when TIMER_CTRL_CAPTURE_EN is defined
//
// Build option: define TIMER_CTRL_CAPTURE_EN to add the input-capture block.
module timer_ctrl #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned PRE_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        we,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        irq,
  input  logic        cap_in
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [2:0] A_CTRL = 3'd0;
  localparam logic [2:0] A_PRE  = 3'd1;
  localparam logic [2:0] A_CMP  = 3'd2;
  localparam logic [2:0] A_CNT  = 3'd3;
  localparam logic [2:0] A_STAT = 3'd4;

  state_t           state, state_nx;
  logic             en, auto_rl, ie;
  logic [PRE_W-1:0] prescale, pre_cnt;
  logic [CNT_W-1:0] compare, count;
  logic             match;
  logic             ctrl_wr, pre_wr, cmp_wr, count_wr, status_wr;
  logic             tick, hit;
  logic [31:0]      rd_mux;

  always_comb begin
    ctrl_wr   = sel && we && (addr == A_CTRL);
    pre_wr    = sel && we && (addr == A_PRE);
    cmp_wr    = sel && we && (addr == A_CMP);
    count_wr  = sel && we && (addr == A_CNT);
    status_wr = sel && we && (addr == A_STAT);
    tick      = (state == RUN) && (pre_cnt == prescale);
    // A software COUNT write swallows the tick, so no compare happens then.
    hit       = tick && !count_wr && (count == compare);
  end

`ifdef TIMER_CTRL_CAPTURE_EN
  localparam logic [2:0] A_CAP = 3'd5;

  logic [1:0]       cap_sync;
  logic             cap_prev;
  logic             cap_flag;
  logic [CNT_W-1:0] capture;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_sync <= '0;
      cap_prev <= 1'b0;
      cap_flag <= 1'b0;
      capture  <= '0;
    end else begin
      cap_sync <= {cap_sync[0], cap_in};
      cap_prev <= cap_sync[1];
      if (cap_sync[1] && !cap_prev) begin
        capture  <= count;
        cap_flag <= 1'b1;
      end else if (status_wr && wdata[1]) begin
        cap_flag <= 1'b0;
      end
    end
  end
`else
  logic cap_flag;
  logic unused_cap;
  assign cap_flag   = 1'b0;
  assign unused_cap = cap_in;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (ctrl_wr && wdata[0]) state_nx = RUN;
      RUN: begin
        if (ctrl_wr)                state_nx = wdata[0] ? RUN : IDLE;
        else if (hit && !auto_rl)   state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en       <= 1'b0;
      auto_rl  <= 1'b0;
      ie       <= 1'b0;
      prescale <= '0;
      compare  <= '0;
      count    <= '0;
      pre_cnt  <= '0;
      match    <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        en      <= wdata[0];
        auto_rl <= wdata[1];
        ie      <= wdata[2];
      end else if (hit && !auto_rl) begin
        en <= 1'b0;
      end
      if (pre_wr) prescale <= wdata[PRE_W-1:0];
      if (cmp_wr) compare  <= wdata[CNT_W-1:0];

      if (count_wr)  count <= wdata[CNT_W-1:0];
      else if (hit)  count <= '0;
      else if (tick) count <= count + CNT_W'(1);

      // Cleared on the edge that leaves RUN so it reads 0 in IDLE/DONE.
      if (state != RUN || state_nx != RUN || tick) pre_cnt <= '0;
      else                                         pre_cnt <= pre_cnt + PRE_W'(1);

      if (hit)                         match <= 1'b1;
      else if (status_wr && wdata[0])  match <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      A_CTRL: rd_mux = {29'b0, ie, auto_rl, en};
      A_PRE:  rd_mux = 32'(prescale);
      A_CMP:  rd_mux = 32'(compare);
      A_CNT:  rd_mux = 32'(count);
      A_STAT: rd_mux = {30'b0, cap_flag, match};
`ifdef TIMER_CTRL_CAPTURE_EN
      A_CAP:  rd_mux = 32'(capture);
`endif
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready <= 1'b0;
      rdata <= '0;
      irq   <= 1'b0;
    end else begin
      ready <= sel;
      if (sel && !we) rdata <= rd_mux;
      irq <= (match | cap_flag) & ie;
    end
  end

endmodule
